soc_system_pio_vga_status: RTL and testbench

- Avalon-MM slave input PIO; the read-side counterpart of the VGA data output PIO.
- Samples an asynchronous status bus from the VGA pixel domain (for example vsync, hsync, FIFO flags) into `clk` and exposes the current level to the HPS.
- Latches edge events per bit and raises a maskable level interrupt.
- Sits on the lightweight HPS-to-FPGA bridge, next to the VGA data PIO.

---
 rtl/soc_system_pio_pkg.sv | 16 +
 rtl/soc_system_pio_sync.sv | 31 +++
 rtl/soc_system_pio_vga_status.sv | 111 +++++++++++
 tb/tb_soc_system_pio_vga_status.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_pkg.sv
// Shared register map and edge-select encodings for the HPS-facing PIO blocks.
package soc_system_pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd1;
   localparam logic [1:0] ADDR_RSVD    = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   // Number of clk edges after reset release before edge detection is trusted.
   localparam logic [1:0] ARM_COUNT = 2'd2;

endpackage

// File: rtl/soc_system_pio_sync.sv
// WIDTH-bit three-flop synchronizer; stage 2 is the usable level, stage 3 its previous value.
module soc_system_pio_sync #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_sync2,
   output logic [WIDTH-1:0] o_sync3
);

   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_sync3;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_sync3 <= '0;
      end else begin
         r_sync1 <= i_d;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign o_sync2 = r_sync2;
   assign o_sync3 = r_sync3;

endmodule

// File: rtl/soc_system_pio_vga_status.sv
// Avalon-MM input PIO for VGA pixel-domain status: synchronized level read-back,
// per-bit edge capture (write-1-to-clear) and a maskable level interrupt.
module soc_system_pio_vga_status
   import soc_system_pio_pkg::*;
#(
   parameter int               WIDTH          = 8,
   parameter int               EDGE_TYPE      = EDGE_RISING,
   parameter logic [WIDTH-1:0] IRQ_RESET_MASK = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] w_sync2;
   logic [WIDTH-1:0] w_sync3;
   logic [WIDTH-1:0] w_det;
   logic [WIDTH-1:0] w_det_armed;
   logic [WIDTH-1:0] w_clr;
   logic [31:0]      w_rd;
   logic             w_wr;
   logic             w_unused;

   logic [1:0]       r_cnt;
   logic             r_armed;
   logic [WIDTH-1:0] r_irq_mask;
   logic [WIDTH-1:0] r_edge_cap;
   logic [31:0]      r_readdata;
   logic             r_irq;

   soc_system_pio_sync #(.WIDTH(WIDTH)) u_sync (
      .i_clk   (clk),
      .i_rst_n (reset_n),
      .i_d     (in_port),
      .o_sync2 (w_sync2),
      .o_sync3 (w_sync3)
   );

   always_comb begin
      w_det = '0;
      case (EDGE_TYPE)
         EDGE_FALLING: w_det = ~w_sync2 & w_sync3;
         EDGE_ANY:     w_det = w_sync2 ^ w_sync3;
         default:      w_det = w_sync2 & ~w_sync3;
      endcase
   end

   // The synchronizer fills with whatever level was present at release; hold
   // detection off until that has propagated so it is not seen as an edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt   <= '0;
         r_armed <= 1'b0;
      end else if (!r_armed) begin
         r_cnt <= r_cnt + 2'd1;
         if (r_cnt == ARM_COUNT) r_armed <= 1'b1;
      end
   end

   assign w_det_armed = r_armed ? w_det : '0;
   assign w_wr        = chipselect & ~write_n;
   assign w_clr       = (w_wr && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
   assign w_unused    = &{1'b0, writedata};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_irq_mask <= IRQ_RESET_MASK;
      end else if (w_wr && address == ADDR_IRQMASK) begin
         r_irq_mask <= writedata[WIDTH-1:0];
      end
   end

   // Set has priority over clear so an edge coinciding with a clear survives.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_edge_cap <= '0;
      end else begin
         r_edge_cap <= (r_edge_cap & ~w_clr) | w_det_armed;
      end
   end

   always_comb begin
      w_rd = '0;
      case (address)
         ADDR_DATA:    w_rd[WIDTH-1:0] = w_sync2;
         ADDR_IRQMASK: w_rd[WIDTH-1:0] = r_irq_mask;
         ADDR_EDGECAP: w_rd[WIDTH-1:0] = r_edge_cap;
         default:      w_rd = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_readdata <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_readdata <= w_rd;
         r_irq      <= |(r_edge_cap & r_irq_mask);
      end
   end

   assign readdata = r_readdata;
   assign irq      = r_irq;

endmodule

// File: tb/tb_soc_system_pio_vga_status.sv
// Directed bench for the VGA status PIO: startup suppression, capture, irq, masking,
// set/clear collision, register map and asynchronous reset.
module tb_soc_system_pio_vga_status;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [7:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   int n_chk;
   int n_err;
   logic [31:0] rdv;

   soc_system_pio_vga_status #(
      .WIDTH          (8),
      .EDGE_TYPE      (0),
      .IRQ_RESET_MASK (8'h40)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      tick();
      d          = readdata;
      chipselect = 1'b0;
   endtask

   initial begin
      n_chk      = 0;
      n_err      = 0;
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = 8'hFF;

      // Startup with all inputs high: no false capture.
      tick(3);
      chk("rst_irq", {31'd0, irq}, 32'd0);
      chk("rst_rd", readdata, 32'd0);
      reset_n = 1'b1;
      tick(10);
      rd(2'd3, rdv); chk("start_cap", rdv, 32'd0);
      chk("start_irq", {31'd0, irq}, 32'd0);
      rd(2'd0, rdv); chk("start_data", rdv, 32'h0000_00FF);
      rd(2'd1, rdv); chk("start_mask", rdv, 32'h0000_0040);

      // Falling edges are ignored with rising detection.
      in_port = 8'h00;
      tick(5);
      rd(2'd3, rdv); chk("fall_ignored", rdv, 32'd0);

      // Rising capture on bit 0, irq one cycle later.
      wr(2'd1, 32'h0000_0001);
      address    = 2'd3;
      chipselect = 1'b1;
      in_port    = 8'h01;
      tick(2);
      chk("e2_data_vis", {31'd0, irq}, 32'd0);
      tick();
      chk("e3_irq_low", {31'd0, irq}, 32'd0);
      chk("e3_cap_pre", readdata, 32'd0);
      tick();
      chk("e4_irq_high", {31'd0, irq}, 32'd1);
      chk("e4_cap", readdata, 32'h0000_0001);
      chipselect = 1'b0;
      wr(2'd3, 32'h0000_0001);
      chk("clr_irq_lag", {31'd0, irq}, 32'd1);
      tick();
      chk("clr_irq_low", {31'd0, irq}, 32'd0);
      rd(2'd3, rdv); chk("clr_cap", rdv, 32'd0);

      // Masked capture on bit 3, then unmask.
      wr(2'd1, 32'h0000_0000);
      in_port = 8'h09;
      tick(4);
      chk("mask_irq_low", {31'd0, irq}, 32'd0);
      rd(2'd3, rdv); chk("mask_cap", rdv, 32'h0000_0008);
      wr(2'd1, 32'h0000_0008);
      chk("unmask_lag", {31'd0, irq}, 32'd0);
      tick();
      chk("unmask_irq", {31'd0, irq}, 32'd1);

      // Bit 2 rises on the very edge that its clear is written: set wins.
      in_port = 8'h0D;
      tick(2);
      wr(2'd3, 32'h0000_0004);
      rd(2'd3, rdv); chk("collide_cap", rdv, 32'h0000_000C);

      // Register map.
      wr(2'd1, 32'hFFFF_FFA5);
      rd(2'd1, rdv); chk("mask_rd", rdv, 32'h0000_00A5);
      wr(2'd0, 32'hFFFF_FFFF);
      rd(2'd1, rdv); chk("data_wr_mask", rdv, 32'h0000_00A5);
      rd(2'd3, rdv); chk("data_wr_cap", rdv, 32'h0000_000C);
      rd(2'd0, rdv); chk("data_rd", rdv, 32'h0000_000D);
      rd(2'd2, rdv); chk("rsvd_rd", rdv, 32'd0);
      address = 2'd3;
      #2;
      chk("rd_hold", readdata, 32'd0);
      tick();
      chk("rd_lat1", readdata, 32'h0000_000C);

      // Build edge_capture = 8'h81 with irq high, then reset mid-operation.
      wr(2'd3, 32'h0000_00FF);
      in_port = 8'h00;
      tick(5);
      in_port = 8'h81;
      tick(5);
      rd(2'd3, rdv); chk("pre_rst_cap", rdv, 32'h0000_0081);
      chk("pre_rst_irq", {31'd0, irq}, 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_irq", {31'd0, irq}, 32'd0);
      chk("async_rd", readdata, 32'd0);
      tick(2);
      reset_n = 1'b1;
      tick(10);
      chk("post_rst_irq", {31'd0, irq}, 32'd0);
      rd(2'd3, rdv); chk("post_rst_cap", rdv, 32'd0);
      rd(2'd1, rdv); chk("post_rst_mask", rdv, 32'h0000_0040);
      rd(2'd0, rdv); chk("post_rst_data", rdv, 32'h0000_0081);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
